// File: rtl/csr_sched.sv
// CSR row-pointer scheduler: slices nnz into N-lane chunks and tags each lane with its row and row-end.
// Optional pointer-format check is enabled by defining CSR_SCHED_PTR_CHECK_EN.
module csr_sched #(
    parameter int N = 16,
    parameter int W = 8,
    localparam int LGN   = $clog2(N),
    localparam int DBLGN = 2 * $clog2(N)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             lhs_start,
    output logic             lhs_ready,
    input  logic [DBLGN-1:0] lhs_ptr [N],
    output logic             chunk_valid,
    input  logic             chunk_ready,
    output logic [DBLGN-1:0] chunk_base,
    output logic [N-1:0]     lane_valid,
    output logic [N-1:0]     split,
    output logic [LGN-1:0]   out_idx [N],
    output logic             carry_in,
    output logic             chunk_last,
    output logic             done,
    output logic             ptr_err
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EMIT,
        ST_FIN
    } state_t;

    state_t             state_reg, state_next;
    logic [DBLGN:0]     base_reg, base_next;
    logic [DBLGN-1:0]   ptr_reg [N];
    logic               load_ptr;
    logic               err_set;
    logic               ptr_bad;

    logic [DBLGN:0]     nnz_ext;
    logic [DBLGN:0]     base_plus_n;
    logic [LGN-1:0]     row_w [N];
    logic [DBLGN-1:0]   lane0_start;
    logic               emit;

    // W belongs to the downstream datapath; this block only requires it to be legal.
    if (W < 1) begin : g_bad_width
    end

    assign emit        = (state_reg == ST_EMIT);
    assign nnz_ext     = {1'b0, ptr_reg[N-1]};
    assign base_plus_n = base_reg + (DBLGN+1)'(N);

`ifdef CSR_SCHED_PTR_CHECK_EN
    logic ptr_err_reg;

    always_comb begin
        ptr_bad = 1'b0;
        for (int i = 1; i < N; i++) begin
            if (lhs_ptr[i] < lhs_ptr[i-1]) begin
                ptr_bad = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_err_reg <= 1'b0;
        end else if (err_set) begin
            ptr_err_reg <= 1'b1;
        end
    end

    assign ptr_err = ptr_err_reg;
`else
    assign ptr_bad = 1'b0;
    assign ptr_err = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        base_next  = base_reg;
        load_ptr   = 1'b0;
        err_set    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (lhs_start) begin
                    load_ptr  = 1'b1;
                    base_next = '0;
                    if (ptr_bad) begin
                        err_set    = 1'b1;
                        state_next = ST_FIN;
                    end else if (lhs_ptr[N-1] != '0) begin
                        state_next = ST_EMIT;
                    end else begin
                        state_next = ST_FIN;
                    end
                end
            end
            ST_EMIT: begin
                if (chunk_ready) begin
                    if (chunk_last) begin
                        state_next = ST_FIN;
                    end else begin
                        base_next = base_plus_n;
                    end
                end
            end
            ST_FIN: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            base_reg  <= '0;
            for (int i = 0; i < N; i++) begin
                ptr_reg[i] <= '0;
            end
        end else begin
            state_reg <= state_next;
            base_reg  <= base_next;
            if (load_ptr) begin
                for (int i = 0; i < N; i++) begin
                    ptr_reg[i] <= lhs_ptr[i];
                end
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_lane
            logic [DBLGN:0]   idx;
            logic [LGN-1:0]   row;
            logic [DBLGN:0]   row_end;
            logic             valid;

            assign idx = base_reg + (DBLGN+1)'(gi);

            // Descending scan leaves the smallest row whose end pointer lies beyond idx.
            always_comb begin
                row = '0;
                for (int i = N - 1; i >= 0; i--) begin
                    if ({1'b0, ptr_reg[i]} > idx) begin
                        row = LGN'(i);
                    end
                end
            end

            assign row_end        = {1'b0, ptr_reg[row]};
            assign valid          = emit && (idx < nnz_ext);
            assign row_w[gi]      = row;
            assign lane_valid[gi] = valid;
            assign split[gi]      = valid && (idx == row_end - (DBLGN+1)'(1));
            assign out_idx[gi]    = valid ? row : '0;
        end
    endgenerate

    // Lane 0 is always a real nonzero while emitting, so its row start is meaningful here.
    assign lane0_start = (row_w[0] == '0) ? '0 : ptr_reg[row_w[0] - LGN'(1)];

    assign lhs_ready   = (state_reg == ST_IDLE);
    assign chunk_valid = emit;
    assign chunk_base  = base_reg[DBLGN-1:0];
    assign carry_in    = emit && (base_reg != '0) && ({1'b0, lane0_start} < base_reg);
    assign chunk_last  = emit && (base_plus_n >= nnz_ext);
    assign done        = (state_reg == ST_FIN);

endmodule

// File: tb/tb_csr_sched.sv
// Directed bench for csr_sched at N=4 with hand-computed chunk descriptors.
module tb_csr_sched;

    logic       clock;
    logic       reset;
    logic       lhs_start;
    logic       lhs_ready;
    logic [3:0] lhs_ptr [4];
    logic       chunk_valid;
    logic       chunk_ready;
    logic [3:0] chunk_base;
    logic [3:0] lane_valid;
    logic [3:0] split;
    logic [1:0] out_idx [4];
    logic       carry_in;
    logic       chunk_last;
    logic       done;
    logic       ptr_err;

    int n_cmp = 0;
    int n_err = 0;

    csr_sched #(.N(4), .W(8)) dut (
        .clock       (clock),
        .reset       (reset),
        .lhs_start   (lhs_start),
        .lhs_ready   (lhs_ready),
        .lhs_ptr     (lhs_ptr),
        .chunk_valid (chunk_valid),
        .chunk_ready (chunk_ready),
        .chunk_base  (chunk_base),
        .lane_valid  (lane_valid),
        .split       (split),
        .out_idx     (out_idx),
        .carry_in    (carry_in),
        .chunk_last  (chunk_last),
        .done        (done),
        .ptr_err     (ptr_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_ptr(input logic [3:0] p0, p1, p2, p3);
        lhs_ptr[0] = p0;
        lhs_ptr[1] = p1;
        lhs_ptr[2] = p2;
        lhs_ptr[3] = p3;
    endtask

    function automatic logic [7:0] idx_vec();
        return {out_idx[3], out_idx[2], out_idx[1], out_idx[0]};
    endfunction

    task automatic chk_chunk(input string tag, input logic [3:0] base, input logic [7:0] idx,
                             input logic [3:0] sp, input logic [3:0] lv, input logic ci, input logic last);
        chk({tag, ".valid"}, chunk_valid, 1'b1);
        chk({tag, ".base"},  chunk_base,  base);
        chk({tag, ".idx"},   idx_vec(),   idx);
        chk({tag, ".split"}, split,       sp);
        chk({tag, ".lanes"}, lane_valid,  lv);
        chk({tag, ".carry"}, carry_in,    ci);
        chk({tag, ".last"},  chunk_last,  last);
        $display("chunk %s base=%0d idx=%h split=%b lanes=%b carry=%0b last=%0b",
                 tag, chunk_base, idx_vec(), split, lane_valid, carry_in, chunk_last);
    endtask

    task automatic accept();
        lhs_start = 1'b1;
        tick();
        lhs_start = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        lhs_start   = 1'b0;
        chunk_ready = 1'b0;
        set_ptr(4'd0, 4'd0, 4'd0, 4'd0);
        tick();
        tick();
        chk("rst.ready", lhs_ready,   1'b1);
        chk("rst.cv",    chunk_valid, 1'b0);
        chk("rst.done",  done,        1'b0);
        chk("rst.err",   ptr_err,     1'b0);
        chk("rst.base",  chunk_base,  4'd0);
        $display("reset: ready=%0b cv=%0b done=%0b err=%0b", lhs_ready, chunk_valid, done, ptr_err);
        reset = 1'b0;
        tick();

        // One nonzero per row: a single complete chunk.
        set_ptr(4'd1, 4'd2, 4'd3, 4'd4);
        chunk_ready = 1'b1;
        accept();
        chk("A.busy", lhs_ready, 1'b0);
        chk_chunk("A0", 4'd0, 8'hE4, 4'b1111, 4'b1111, 1'b0, 1'b1);
        tick();
        chk("A.done", done, 1'b1);
        chk("A.cv",   chunk_valid, 1'b0);
        tick();
        chk("A.done_off", done, 1'b0);
        chk("A.ready", lhs_ready, 1'b1);

        // Long row 0, empty row 1, two single rows.
        set_ptr(4'd6, 4'd6, 4'd7, 4'd8);
        accept();
        chk_chunk("B0", 4'd0, 8'h00, 4'b0000, 4'b1111, 1'b0, 1'b0);
        tick();
        chk_chunk("B1", 4'd4, 8'hE0, 4'b1110, 4'b1111, 1'b1, 1'b1);
        tick();
        chk("B.done", done, 1'b1);
        tick();

        // Empty matrix: straight to FIN.
        set_ptr(4'd0, 4'd0, 4'd0, 4'd0);
        accept();
        chk("C.cv",   chunk_valid, 1'b0);
        chk("C.done", done, 1'b1);
        tick();
        chk("C.done_off", done, 1'b0);
        chk("C.ready", lhs_ready, 1'b1);

        // Stall for three cycles; a stray start during the stall is ignored.
        set_ptr(4'd2, 4'd3, 4'd3, 4'd5);
        chunk_ready = 1'b0;
        accept();
        chk_chunk("D0", 4'd0, 8'hD0, 4'b0110, 4'b1111, 1'b0, 1'b0);
        for (int s = 0; s < 3; s++) begin
            if (s == 1) begin
                set_ptr(4'd1, 4'd1, 4'd1, 4'd1);
                lhs_start = 1'b1;
            end else begin
                lhs_start = 1'b0;
            end
            tick();
            chk_chunk("D0stall", 4'd0, 8'hD0, 4'b0110, 4'b1111, 1'b0, 1'b0);
        end
        lhs_start   = 1'b0;
        chunk_ready = 1'b1;
        tick();
        chk_chunk("D1", 4'd4, 8'h03, 4'b0001, 4'b0001, 1'b1, 1'b1);
        tick();
        chk("D.done", done, 1'b1);
        tick();

        // Reset during the second chunk drops the matrix.
        set_ptr(4'd2, 4'd3, 4'd3, 4'd5);
        accept();
        tick();
        chk("E.base1", chunk_base, 4'd4);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("E.ready", lhs_ready, 1'b1);
        chk("E.cv",    chunk_valid, 1'b0);
        chk("E.done0", done, 1'b0);
        tick();
        chk("E.done1", done, 1'b0);
        $display("reset mid-emit: ready=%0b done=%0b", lhs_ready, done);
        set_ptr(4'd1, 4'd2, 4'd3, 4'd4);
        accept();
        chk_chunk("E0", 4'd0, 8'hE4, 4'b1111, 4'b1111, 1'b0, 1'b1);
        tick();
        chk("E.done", done, 1'b1);
        tick();

`ifdef CSR_SCHED_PTR_CHECK_EN
        // Non-monotone pointers: error, no chunks, single done pulse.
        set_ptr(4'd3, 4'd2, 4'd4, 4'd4);
        accept();
        chk("F.err",  ptr_err, 1'b1);
        chk("F.cv",   chunk_valid, 1'b0);
        chk("F.done", done, 1'b1);
        tick();
        chk("F.done_off", done, 1'b0);
        chk("F.err_hold", ptr_err, 1'b1);
        chk("F.cv2",  chunk_valid, 1'b0);
        $display("ptr check: err=%0b", ptr_err);
`else
        chk("F.err_tied", ptr_err, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
